// File: rtl/instr_encoder_loader.sv
// Boot-time RV32I program loader: packs instruction descriptors into machine words,
// streams them into instruction memory and holds the core in reset until END arrives.
module instr_encoder_loader #(
  parameter int          ADDR_WIDTH = 6,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [2:0]            in_kind_i,
  input  logic [2:0]            in_alu_i,
  input  logic [4:0]            in_rd_i,
  input  logic [4:0]            in_rs1_i,
  input  logic [4:0]            in_rs2_i,
  input  logic [20:0]           in_imm_i,
  output logic                  mem_we_o,
  output logic [31:0]           mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic                  cpu_reset_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCEPT = 3'd1,
    S_WRITE  = 3'd2,
    S_DONE   = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  localparam logic [2:0] K_LW  = 3'd0;
  localparam logic [2:0] K_SW  = 3'd1;
  localparam logic [2:0] K_R   = 3'd2;
  localparam logic [2:0] K_BEQ = 3'd3;
  localparam logic [2:0] K_I   = 3'd4;
  localparam logic [2:0] K_JAL = 3'd5;
  localparam logic [2:0] K_END = 3'd6;

  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_MAX = 3'd4;

  localparam logic [ADDR_WIDTH:0] CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};

  function automatic logic [2:0] alu_f3(input logic [2:0] alu);
    logic [2:0] f3;
    case (alu)
      3'd0, 3'd1: f3 = 3'b000;
      3'd2:       f3 = 3'b010;
      3'd3:       f3 = 3'b110;
      3'd4:       f3 = 3'b111;
      default:    f3 = 3'b000;
    endcase
    return f3;
  endfunction

  function automatic logic fits_12(input logic [20:0] imm);
    return (imm[20:11] == 10'h000) || (imm[20:11] == 10'h3FF);
  endfunction

  function automatic logic fits_13(input logic [20:0] imm);
    return (imm[20:12] == 9'h000) || (imm[20:12] == 9'h1FF);
  endfunction

  function automatic logic desc_legal(input logic [2:0] kind, input logic [2:0] alu,
                                      input logic [20:0] imm);
    logic ok;
    case (kind)
      K_LW, K_SW: ok = fits_12(imm);
      K_R:        ok = (alu <= ALU_MAX);
      K_BEQ:      ok = fits_13(imm) && (imm[0] == 1'b0);
      K_I:        ok = (alu <= ALU_MAX) && (alu != ALU_SUB) && fits_12(imm);
      K_JAL:      ok = (imm[0] == 1'b0);
      K_END:      ok = 1'b1;
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [31:0] encode_word(input logic [2:0] kind, input logic [2:0] alu,
                                              input logic [4:0] rd, input logic [4:0] rs1,
                                              input logic [4:0] rs2, input logic [20:0] imm);
    logic [31:0] word;
    logic [6:0]  f7;
    logic [2:0]  f3;
    f3 = alu_f3(alu);
    f7 = (alu == ALU_SUB) ? 7'b0100000 : 7'b0000000;
    case (kind)
      K_LW:    word = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
      K_SW:    word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
      K_R:     word = {f7, rs2, rs1, f3, rd, 7'b0110011};
      K_BEQ:   word = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
      K_I:     word = {imm[11:0], rs1, f3, rd, 7'b0010011};
      K_JAL:   word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
      default: word = 32'h0000_0000;
    endcase
    return word;
  endfunction

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  in_ready_q, mem_we_q, busy_q, done_q, error_q, cpu_reset_q;
  logic                  accept_s;

  assign accept_s = in_valid_i && in_ready_q;

  // Next-state, write capture and session bookkeeping; start overrides everything.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (start_i) begin
      state_d = S_ACCEPT;
      count_d = {(ADDR_WIDTH+1){1'b0}};
    end else begin
      case (state_q)
        S_ACCEPT: begin
          if (accept_s) begin
            if (in_kind_i == K_END) begin
              state_d = S_DONE;
            end else if (!desc_legal(in_kind_i, in_alu_i, in_imm_i) || (count_q == CAPACITY)) begin
              state_d = S_ERR;
            end else begin
              state_d = S_WRITE;
              addr_d  = BASE_ADDR + 32'({count_q, 2'b00});
              wdata_d = encode_word(in_kind_i, in_alu_i, in_rd_i, in_rs1_i, in_rs2_i, in_imm_i);
            end
          end else begin
            state_d = state_q;
          end
        end
        S_WRITE: begin
          state_d = S_ACCEPT;
          count_d = count_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
        end
        default: state_d = state_q;
      endcase
    end
  end

  // State, datapath and output registers; status outputs track the upcoming state.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      count_q     <= {(ADDR_WIDTH+1){1'b0}};
      addr_q      <= 32'h0000_0000;
      wdata_q     <= 32'h0000_0000;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      cpu_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      in_ready_q  <= (state_d == S_ACCEPT);
      mem_we_q    <= (state_d == S_WRITE);
      busy_q      <= (state_d == S_ACCEPT) || (state_d == S_WRITE);
      done_q      <= (state_d == S_DONE);
      error_q     <= (state_d == S_ERR);
      cpu_reset_q <= (state_d != S_DONE);
    end
  end

  assign in_ready_o  = in_ready_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign count_o     = count_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign error_o     = error_q;
  assign cpu_reset_o = cpu_reset_q;

endmodule
